// File: rtl/eight_source_round_robin_arbiter_pkg.sv
// Shared constants and state encoding for the eight-source round-robin arbiter.
// Imported by the priority picker and the arbiter top level.
package eight_source_round_robin_arbiter_pkg;

    localparam int NUM_SOURCES = 8;
    localparam int SEL_W       = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/eight_source_round_robin_arbiter_rr_priority_pick.sv
// Rotating priority picker: first set REQ bit at or after PTR (mod 8).
// Ports: REQ/PTR in; FOUND, WINNER index and one-hot GRANT_1H out.
module rr_priority_pick
    import eight_source_round_robin_arbiter_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [SEL_W-1:0]       ptr,
    output logic                   found,
    output logic [SEL_W-1:0]       winner,
    output logic [NUM_SOURCES-1:0] grant_1h
);

    logic [NUM_SOURCES-1:0] rot;
    logic [SEL_W-1:0]       idx;

    always_comb begin
        // rot[j] = req[(j + ptr) mod 8], so bit 0 is the current favourite
        rot = NUM_SOURCES'({req, req} >> ptr);
        found = |rot;
        idx = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (rot[i]) idx = SEL_W'(i);
        end
        winner = idx + ptr;
        grant_1h = found ? (NUM_SOURCES'(1) << winner) : '0;
    end

endmodule

// File: rtl/eight_source_round_robin_arbiter.sv
// Round-robin arbiter sharing one BITS-wide result path among eight sources.
// Ports: CLK, RESET, REQ/DATA/ACK per source; OUT_VALID/OUT_DATA/OUT_SELECT/OUT_READY downstream.
module eight_source_round_robin_arbiter
    import eight_source_round_robin_arbiter_pkg::*;
#(
    parameter int BITS = 3
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic [NUM_SOURCES-1:0]              REQ,
    input  logic [NUM_SOURCES-1:0][BITS-1:0]    DATA,
    output logic [NUM_SOURCES-1:0]              ACK,
    output logic                                OUT_VALID,
    output logic [BITS-1:0]                     OUT_DATA,
    output logic [SEL_W-1:0]                    OUT_SELECT,
    input  logic                                OUT_READY
);

    state_t                 state;
    state_t                 state_nxt;
    logic [SEL_W-1:0]       ptr;
    logic                   found;
    logic [SEL_W-1:0]       winner;
    logic [NUM_SOURCES-1:0] grant_1h;
    logic                   capture;
    logic [BITS-1:0]        data_sel;

    rr_priority_pick u_pick (
        .req      (REQ),
        .ptr      (ptr),
        .found    (found),
        .winner   (winner),
        .grant_1h (grant_1h)
    );

    assign data_sel = DATA[winner];

    // The output slot is free when empty or being drained this edge;
    // reset suppresses any grant so no word is consumed while held.
    assign capture = found && (state == EMPTY || OUT_READY) && !RESET;

    assign ACK       = capture ? grant_1h : '0;
    assign OUT_VALID = (state == FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (capture) state_nxt = FULL;
            FULL:  if (OUT_READY && !capture) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= EMPTY;
            ptr        <= '0;
            OUT_DATA   <= '0;
            OUT_SELECT <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                ptr        <= winner + SEL_W'(1);
                OUT_DATA   <= data_sel;
                OUT_SELECT <= winner;
            end
        end
    end

endmodule

// File: doc/eight_source_round_robin_arbiter.md
# eight_source_round_robin_arbiter

Round-robin arbiter that shares a single BITS-wide result path among eight requesters. It picks one pending requester per cycle and drives the 3-bit select of an 8:1 data mux with the winner's index. It captures the selected word into a one-entry output register and hands it downstream over a valid/ready handshake. It sits between the eight producer units and the single consumer port that they contend for.

## Interface
- BITS, default 3: width of each requester data word and of OUT_DATA.

- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  8  REQ[i]=1 means requester i presents a valid word on DATA[i].
- DATA  input  8×BITS  packed [7:0][BITS-1:0]; DATA[i] belongs to requester i.
- ACK  output  8  one-hot, combinational; ACK[i]=1 means DATA[i] is captured at this clock edge.
- OUT_VALID  output  1  the output register holds a word.
- OUT_DATA  output  BITS  captured word.
- OUT_SELECT  output  3  index of the requester whose word is in OUT_DATA.
- OUT_READY  input  1  consumer accepts OUT_DATA when OUT_VALID & OUT_READY.

## Operation
- State: PTR[2:0] is the highest-priority index. STATE is EMPTY or FULL, and OUT_VALID = (STATE==FULL).
- Winner: the first index i in the order PTR, PTR+1, …, PTR+7 (mod 8) with REQ[i]=1. If REQ=0, there is no winner.
- Capture condition: a winner exists AND (STATE==EMPTY OR OUT_READY==1).
- On capture:
  - ACK[winner]=1, and all other ACK bits are 0.
  - OUT_DATA<=DATA[winner], OUT_SELECT<=winner, STATE<=FULL.
  - PTR<=winner+1 mod 8, so 7 wraps to 0.
- If there is no capture, ACK=0 and PTR holds.
- STATE transitions:
  - EMPTY → FULL on capture.
  - EMPTY → EMPTY otherwise.
  - FULL with OUT_READY=1 and capture → FULL, loading the new word in the same cycle (back-to-back transfer).
  - FULL with OUT_READY=1 and no capture → EMPTY.
  - FULL with OUT_READY=0 → FULL. OUT_DATA and OUT_SELECT are stable, and ACK=0.
- Requesters treat ACK as consumption. A requester that keeps REQ high after ACK is presenting a new word.
- Fairness: a continuously requesting source waits at most 7 captures.
- REQ bits that change while no capture occurs are re-evaluated every cycle. There is no grant locking.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SELECT=0, PTR=0, STATE=EMPTY.
- While RESET=1, ACK=0 regardless of REQ.
- Reset asserted mid-transfer discards the held word immediately (asynchronously). No ACK is issued during reset.
- ACK is a same-cycle combinational function of REQ, PTR, STATE and OUT_READY. There is no combinational path from DATA to ACK.
- Latency: a word captured at edge N appears with OUT_VALID=1 after edge N.
- Throughput: one word per cycle while OUT_READY=1 and any REQ is set.
- OUT_DATA and OUT_SELECT change only at a capture edge or on reset.

## Structure
- Shared package: constant NUM_SOURCES=8, constant SEL_W=3, and the state enum {EMPTY, FULL}.
- Sub-module rr_priority_pick: combinational.
  - Inputs: REQ[7:0], PTR[2:0].
  - Outputs: FOUND, WINNER[2:0], GRANT_1H[7:0].
  - Implemented as a rotate-by-PTR, a fixed-priority encode, and an add-back of PTR.
- Data selection is an 8:1 mux of DATA indexed by WINNER. It is instantiated in the top level.

## Test plan
- Reset release, REQ=8'h00, OUT_READY=1 for 5 cycles → ACK=0, OUT_VALID=0, OUT_DATA=0.
- REQ=8'hFF held, DATA[i]=i, OUT_READY=1, starting from PTR=0 → ACK walks 0,1,…,7,0. OUT_SELECT and OUT_DATA follow one cycle later, and OUT_VALID stays 1 continuously.
- REQ=8'h81, PTR=0, OUT_READY=1 → grants go 0, 7, 0, 7. After the grant to 7, PTR wraps to 0.
- Capture from source 3 with OUT_READY=0 for 4 cycles while REQ=8'h20:
  - During the stall: ACK=0, OUT_DATA holds DATA[3], OUT_SELECT=3.
  - First cycle OUT_READY=1: ACK=8'h20, and the next OUT_SELECT=5.
- OUT_VALID=1 with REQ=0 and OUT_READY=1 → OUT_VALID=0 after the edge, and PTR is unchanged.
- RESET asserted asynchronously mid-cycle while FULL with REQ=8'hFF → OUT_VALID=0 and ACK=0 immediately.
  - After release: first grant goes to source 0.
